// File: rtl/mips_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the FSM state encoding, the register-index/data widths and the buffered-entry layout.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbarb_fifo.sv
// Small FIFO of {rd, data} results waiting for a free register-file write slot.
// DEPTH must be a power of two so that the read/write pointers wrap naturally.
module wbarb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and buffered
// multiply/divide results, with starvation-forced stalls and a pending-destination scoreboard.
module regfile_wport_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic              md_issue,
  input  logic [REG_W-1:0]  md_issue_rd,
  input  logic [REG_W-1:0]  dec_rs,
  input  logic [REG_W-1:0]  dec_rt,
  output logic              dec_hazard,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output arb_state_e        dbg_state
);

  // Handshake: an MD result transfers on a cycle where md_valid && md_ready; md_ready is
  // purely combinational from the buffer occupancy and does not look at md_valid.

  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_state_e         state_q, state_d;
  logic [SC_W-1:0]    starve_q, starve_d;
  logic [31:0]        pend_q, pend_d;
  logic               rf_we_q;
  logic [REG_W-1:0]   rf_addr_q;
  logic [DATA_W-1:0]  rf_data_q;

  wb_entry_t          fifo_head;
  wb_entry_t          fifo_in;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               last_entry;

  logic               grant;
  logic               md_grant;
  logic [REG_W-1:0]   grant_rd;
  logic [DATA_W-1:0]  grant_data;
  logic [31:0]        set_mask;
  logic [31:0]        clr_mask;

  assign md_ready     = !fifo_full;
  assign fifo_push    = md_valid && md_ready;
  assign fifo_in.rd   = md_rd;
  assign fifo_in.data = md_data;
  assign last_entry   = (fifo_count == CNT_W'(1));

  wbarb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    fifo_pop = 1'b0;
    grant    = 1'b0;
    case (state_q)
      IDLE: begin
        grant = wb_we;
        if (fifo_push) state_d = PEND;
      end
      PEND: begin
        if (wb_we) begin
          grant = 1'b1;
          if (starve_q == SC_W'(STARVE_LIMIT - 1)) begin
            state_d  = FORCE;
            starve_d = '0;
          end else begin
            starve_d = starve_q + SC_W'(1);
          end
        end else begin
          fifo_pop = 1'b1;
          starve_d = '0;
          if (last_entry && !fifo_push) state_d = IDLE;
        end
      end
      FORCE: begin
        fifo_pop = 1'b1;
        starve_d = '0;
        state_d  = (last_entry && !fifo_push) ? IDLE : PEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // The buffered head takes the slot whenever a pop happens; otherwise the pipeline owns it.
  always_comb begin
    md_grant   = fifo_pop && !fifo_empty;
    grant_rd   = wb_rd;
    grant_data = wb_data;
    if (md_grant) begin
      grant_rd   = fifo_head.rd;
      grant_data = fifo_head.data;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (md_issue && (md_issue_rd != REG_ZERO)) set_mask = 32'd1 << md_issue_rd;
    if (md_grant) clr_mask = 32'd1 << fifo_head.rd;
    pend_d = (pend_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      pend_q  <= pend_d;
      rf_we_q <= (grant || md_grant) && (grant_rd != REG_ZERO);
      if (grant || md_grant) begin
        rf_addr_q <= grant_rd;
        rf_data_q <= grant_data;
      end
    end
  end

  assign wb_stall   = (state_q == FORCE);
  assign dec_hazard = pend_q[dec_rs] | pend_q[dec_rt];
  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench: a queue-based reference model predicts every register-file write,
// and a negedge monitor pops and compares them as the DUT presents rf_we.
module tb_regfile_wport_arbiter;
  import mips_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic        dec_hazard;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  arb_state_e  dbg_state;

  regfile_wport_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_stall    (wb_stall),
    .md_valid    (md_valid),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .md_ready    (md_ready),
    .md_issue    (md_issue),
    .md_issue_rd (md_issue_rd),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_hazard  (dec_hazard),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // ---------------- scoreboard / reference model ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [52:0] exp_q[$];     // {cycle stamp, rd, data} of each expected write
  logic [36:0] m_q[$];       // buffered MD results {rd, data}
  logic [31:0] m_pend;       // registers with an outstanding MD write
  int          m_wait;       // pipeline writes seen while the buffer was non-empty
  logic        m_force;      // next slot must go to the buffer
  logic        acc;          // MD offer accepted in the last cycle
  logic        stalled;      // pipeline write held in the last cycle
  logic [4:0]  iss_q[$];     // issued MD ops still awaiting their result offer

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    exp_q.delete();
    iss_q.delete();
    m_pend  = '0;
    m_wait  = 0;
    m_force = 1'b0;
  endtask

  task automatic inputs_idle();
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
    md_issue = 1'b0; md_issue_rd = '0;
    dec_rs = '0; dec_rt = '0;
  endtask

  // One clock cycle: inputs are already driven; check combinational outputs, advance the model.
  task automatic cycle();
    logic [36:0] h;
    arb_state_e  es;
    #1;
    es = m_force ? FORCE : ((m_q.size() > 0) ? PEND : IDLE);
    chk("wb_stall",   64'(wb_stall),   64'(m_force));
    chk("md_ready",   64'(md_ready),   64'(m_q.size() < DEPTH));
    chk("dec_hazard", 64'(dec_hazard), 64'(m_pend[dec_rs] | m_pend[dec_rt]));
    chk("state",      64'(dbg_state),  64'(es));
    if (md_issue && md_issue_rd != 5'd0 && m_pend[md_issue_rd]) begin
      n_fail++;
      $display("FAIL issue_protocol: rd %0d issued while pending", md_issue_rd);
    end
    stalled = m_force && wb_we;
    acc     = md_valid && (m_q.size() < DEPTH);
    if (m_q.size() > 0 && (m_force || !wb_we)) begin
      h = m_q.pop_front();
      if (h[36:32] != 5'd0) exp_q.push_back({cyc + 16'd1, h});
      m_pend[h[36:32]] = 1'b0;
      m_wait  = 0;
      m_force = 1'b0;
    end else if (wb_we) begin
      if (wb_rd != 5'd0) exp_q.push_back({cyc + 16'd1, wb_rd, wb_data});
      if (m_q.size() > 0) begin
        m_wait++;
        if (m_wait == STARVE_LIMIT) begin
          m_force = 1'b1;
          m_wait  = 0;
        end
      end
    end
    if (acc) m_q.push_back({md_rd, md_data});
    if (md_issue && md_issue_rd != 5'd0) m_pend[md_issue_rd] = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0][52:37] < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missing_write: got none expected rd %0d data %0h at cycle %0d",
                 exp_q[0][36:32], exp_q[0][31:0], exp_q[0][52:37]);
        void'(exp_q.pop_front());
      end
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got rd %0d data %0h expected no write", rf_addr, rf_data);
        end else begin
          chk("rf_write", 64'({cyc, rf_addr, rf_data}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    inputs_idle();
    model_clear();
    acc = 1'b0; stalled = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_rf_we",    64'(rf_we),      64'(0));
    chk("rst_rf_addr",  64'(rf_addr),    64'(0));
    chk("rst_rf_data",  64'(rf_data),    64'(0));
    chk("rst_wb_stall", 64'(wb_stall),   64'(0));
    chk("rst_md_ready", 64'(md_ready),   64'(1));
    chk("rst_hazard",   64'(dec_hazard), 64'(0));
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Pipeline only
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    cycle();
    inputs_idle();
    repeat (2) cycle();

    // MD result into an idle slot, with decode hazard tracking
    md_issue = 1'b1; md_issue_rd = 5'd9;
    cycle();
    inputs_idle();
    dec_rs = 5'd9;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'hCAFE;
    cycle();
    md_valid = 1'b0;
    repeat (3) cycle();
    inputs_idle();

    // Starvation: one buffered entry under continuous pipeline writes
    md_valid = 1'b1; md_rd = 5'd12; md_data = 32'h5A5A;
    for (int i = 0; i < 8; i++) begin
      wb_we = 1'b1; wb_rd = 5'(16 + i); wb_data = 32'h100 + i;
      cycle();
      if (acc) md_valid = 1'b0;
      if (stalled) i--;
    end
    inputs_idle();
    repeat (2) cycle();

    // Full buffer: third offer held until a dequeue, order preserved
    md_issue = 1'b1; md_issue_rd = 5'd3;
    cycle();
    md_issue_rd = 5'd4;
    wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'hA0;
    md_valid = 1'b1; md_rd = 5'd3; md_data = 32'hA1;
    cycle();
    md_issue_rd = 5'd6;
    md_rd = 5'd4; md_data = 32'hA2;
    cycle();
    md_issue = 1'b0;
    md_rd = 5'd6; md_data = 32'hA3;
    for (int i = 0; i < 20 && md_valid; i++) begin
      wb_data = 32'hB0 + i;
      cycle();
      if (acc) md_valid = 1'b0;
    end
    chk("third_accepted", 64'(md_valid), 64'(0));
    inputs_idle();
    repeat (4) cycle();

    // Register 0 from both sources: slots consumed, no rf_we
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'hBEEF;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    cycle();
    md_valid = 1'b0; wb_we = 1'b0;
    cycle();
    wb_we = 1'b1; wb_rd = 5'd0;
    cycle();
    inputs_idle();
    cycle();

    // Async reset with two buffered entries and a non-empty scoreboard
    md_issue = 1'b1; md_issue_rd = 5'd7;
    cycle();
    md_issue_rd = 5'd8;
    wb_we = 1'b1; wb_rd = 5'd21; wb_data = 32'hC0;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hC7;
    cycle();
    md_issue = 1'b0;
    md_rd = 5'd8; md_data = 32'hC8;
    cycle();
    md_valid = 1'b0;
    dec_rs = 5'd7;
    #2 reset = 1'b1;
    #1;
    chk("arst_rf_we",    64'(rf_we),      64'(0));
    chk("arst_rf_addr",  64'(rf_addr),    64'(0));
    chk("arst_rf_data",  64'(rf_data),    64'(0));
    chk("arst_wb_stall", 64'(wb_stall),   64'(0));
    chk("arst_md_ready", 64'(md_ready),   64'(1));
    chk("arst_hazard",   64'(dec_hazard), 64'(0));
    model_clear();
    inputs_idle();
    @(posedge clk);
    #4 reset = 1'b0;
    @(posedge clk); #1;
    dec_rs = 5'd7; dec_rt = 5'd8;
    repeat (6) cycle();
    inputs_idle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!stalled) begin
        wb_we   = ($urandom_range(0, 99) < ((c < 300) ? 85 : 45));
        wb_rd   = 5'($urandom_range(0, 31));
        wb_data = $urandom;
      end
      md_issue = 1'b0;
      if (iss_q.size() < 4 && $urandom_range(0, 2) == 0) begin
        for (int t = 0; t < 8 && !md_issue; t++) begin
          md_issue_rd = 5'($urandom_range(0, 31));
          if (md_issue_rd == 5'd0 || !m_pend[md_issue_rd]) md_issue = 1'b1;
        end
      end
      if (!md_valid && iss_q.size() > 0 && $urandom_range(0, 1) == 0) begin
        md_valid = 1'b1;
        md_rd    = iss_q[0];
        md_data  = $urandom;
      end
      dec_rs = 5'($urandom_range(0, 31));
      dec_rt = 5'($urandom_range(0, 31));
      cycle();
      if (md_issue) iss_q.push_back(md_issue_rd);
      if (acc) begin
        md_valid = 1'b0;
        void'(iss_q.pop_front());
      end
    end

    inputs_idle();
    repeat (DEPTH * (STARVE_LIMIT + 1) + 4) cycle();
    @(negedge clk); #1;
    chk("drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
